// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// cla_12bit
//   12-bit carry-lookahead adder built from three 4-bit lookahead groups.
//   Ports: a, b (operands), c_in (carry in), sum (a+b+c_in mod 2^12),
//          c_out (carry out of bit 11).
// ---------------------------------------------------------------------------
module cla_12bit (
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        c_in,
    output logic [11:0] sum,
    output logic        c_out
);

    localparam int unsigned W      = 12;
    localparam int unsigned GRP_W  = 4;
    localparam int unsigned N_GRP  = 3;

    logic [W-1:0]       g;
    logic [W-1:0]       p;
    logic [W-1:0]       c;
    logic [N_GRP-1:0]   grp_g;
    logic [N_GRP-1:0]   grp_p;
    logic [N_GRP-1:0]   grp_c;

    // Carries inside one 4-bit group, fully expanded from the group carry-in.
    function automatic logic [3:0] grp_carry(input logic [3:0] gg,
                                             input logic [3:0] pp,
                                             input logic       ci);
        logic [3:0] cc;
        cc[0] = ci;
        cc[1] = gg[0] | (pp[0] & ci);
        cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
              | (pp[2] & pp[1] & pp[0] & ci);
        return cc;
    endfunction

    // Group generate/propagate and second-level lookahead across groups.
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < int'(N_GRP); k++) begin
            grp_g[k] = g[k*GRP_W+3]
                     | (p[k*GRP_W+3] & g[k*GRP_W+2])
                     | (p[k*GRP_W+3] & p[k*GRP_W+2] & g[k*GRP_W+1])
                     | (p[k*GRP_W+3] & p[k*GRP_W+2] & p[k*GRP_W+1] & g[k*GRP_W]);
            grp_p[k] = &p[k*GRP_W +: GRP_W];
        end
        grp_c[0] = c_in;
        grp_c[1] = grp_g[0] | (grp_p[0] & c_in);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_in);
        c_out    = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);
        for (int k = 0; k < int'(N_GRP); k++) begin
            c[k*GRP_W +: GRP_W] = grp_carry(g[k*GRP_W +: GRP_W], p[k*GRP_W +: GRP_W], grp_c[k]);
        end
        sum = p ^ c;
    end

endmodule

// ---------------------------------------------------------------------------
// if_fetch_unit
//   IF-stage fetch front end: owns the PC, issues one outstanding request at
//   a time on a req/ack instruction-memory handshake, buffers returned words
//   in a one-entry skid plus the IF/ID output register, honours decode stalls
//   and EX redirects.
//   Ports:
//     i_clk, i_reset          clock, async active-high reset
//     o_imem_req/o_imem_addr  request valid / word-aligned byte address
//     i_imem_ack/i_imem_rdata response valid / instruction word
//     i_stall                 decode cannot accept o_if_*
//     i_redirect_valid/_pc    one-cycle redirect from EX and its target
//     o_if_valid/_pc/_instr   IF/ID register contents (NOP when not valid)
//     o_pc_wrap               pulse when the PC increments from FFC to 000
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [11:0] RESET_PC  = 12'h000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [11:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [11:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [11:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_pc_wrap
);

    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [PC_W-1:0]    pc_q, pc_n;
    logic               req_q, req_n;
    logic [PC_W-1:0]    req_addr_q, req_addr_n;
    logic               out_valid_q, out_valid_n;
    logic [PC_W-1:0]    out_pc_q, out_pc_n;
    logic [INSTR_W-1:0] out_instr_q, out_instr_n;
    logic               skid_valid_q, skid_valid_n;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_n;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_n;
    logic               pc_wrap_q, pc_wrap_n;

    logic [PC_W-1:0]    redir_pc;
    logic [PC_W-1:0]    pc_inc;
    logic               pc_inc_co;
    logic [PC_W-1:0]    redir_inc;
    logic               redir_inc_co;
    logic               ack_fire;
    logic               out_free;

    // Redirect targets are always word aligned.
    assign redir_pc = i_redirect_pc & ~PC_W'(3);

    cla_12bit u_pc_inc (
        .a     (pc_q),
        .b     (PC_W'(4)),
        .c_in  (1'b0),
        .sum   (pc_inc),
        .c_out (pc_inc_co)
    );

    cla_12bit u_redir_inc (
        .a     (redir_pc),
        .b     (PC_W'(4)),
        .c_in  (1'b0),
        .sum   (redir_inc),
        .c_out (redir_inc_co)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_instr_q  <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            pc_wrap_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            pc_q         <= pc_n;
            req_q        <= req_n;
            req_addr_q   <= req_addr_n;
            out_valid_q  <= out_valid_n;
            out_pc_q     <= out_pc_n;
            out_instr_q  <= out_instr_n;
            skid_valid_q <= skid_valid_n;
            skid_pc_q    <= skid_pc_n;
            skid_instr_q <= skid_instr_n;
            pc_wrap_q    <= pc_wrap_n;
        end
    end

    // Next-state, buffering and request-issue logic.
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        req_n        = req_q;
        req_addr_n   = req_addr_q;
        out_valid_n  = out_valid_q;
        out_pc_n     = out_pc_q;
        out_instr_n  = out_instr_q;
        skid_valid_n = skid_valid_q;
        skid_pc_n    = skid_pc_q;
        skid_instr_n = skid_instr_q;
        pc_wrap_n    = 1'b0;
        ack_fire     = req_q && i_imem_ack;
        out_free     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_n    = ST_FETCH;
                req_n      = 1'b1;
                req_addr_n = pc_q;
                pc_n       = pc_inc;
                pc_wrap_n  = pc_inc_co;
            end

            ST_FETCH: begin
                if (i_redirect_valid) begin
                    // Squash everything younger than the redirecting branch.
                    out_valid_n  = 1'b0;
                    out_instr_n  = NOP_INSTR;
                    skid_valid_n = 1'b0;
                    if (req_q && !i_imem_ack) begin
                        // Keep the stale request up until memory answers it.
                        state_n = ST_DRAIN;
                        pc_n    = redir_pc;
                    end else begin
                        req_n      = 1'b1;
                        req_addr_n = redir_pc;
                        pc_n       = redir_inc;
                        pc_wrap_n  = redir_inc_co;
                    end
                end else begin
                    out_free = !out_valid_q || !i_stall;

                    // Older skid word has priority for the freed output slot.
                    if (out_free) begin
                        out_valid_n = 1'b0;
                        out_instr_n = NOP_INSTR;
                        if (skid_valid_q) begin
                            out_valid_n  = 1'b1;
                            out_pc_n     = skid_pc_q;
                            out_instr_n  = skid_instr_q;
                            skid_valid_n = 1'b0;
                        end
                    end

                    if (ack_fire) begin
                        if (out_free && !skid_valid_q) begin
                            out_valid_n = 1'b1;
                            out_pc_n    = req_addr_q;
                            out_instr_n = i_imem_rdata;
                        end else begin
                            skid_valid_n = 1'b1;
                            skid_pc_n    = req_addr_q;
                            skid_instr_n = i_imem_rdata;
                        end
                    end

                    // Only fetch ahead when there is guaranteed room to land it.
                    if ((ack_fire || !req_q) && !skid_valid_n) begin
                        req_n      = 1'b1;
                        req_addr_n = pc_q;
                        pc_n       = pc_inc;
                        pc_wrap_n  = pc_inc_co;
                    end else if (ack_fire) begin
                        req_n = 1'b0;
                    end
                end
            end

            ST_DRAIN: begin
                if (i_redirect_valid) begin
                    pc_n = redir_pc;
                end
                // Stale response is dropped; restart at the current target.
                if (ack_fire) begin
                    state_n = ST_FETCH;
                    req_n   = 1'b1;
                    if (i_redirect_valid) begin
                        req_addr_n = redir_pc;
                        pc_n       = redir_inc;
                        pc_wrap_n  = redir_inc_co;
                    end else begin
                        req_addr_n = pc_q;
                        pc_n       = pc_inc;
                        pc_wrap_n  = pc_inc_co;
                    end
                end
            end

            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = req_addr_q;
    assign o_if_valid  = out_valid_q;
    assign o_if_pc     = out_pc_q;
    assign o_if_instr  = out_instr_q;
    assign o_pc_wrap   = pc_wrap_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a word-addressed memory responder with a
// programmable ack delay, a program-order model of issued addresses and
// delivered instructions checked every cycle, and directed literal checks.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b0;
    logic        o_imem_req;
    logic [11:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_redirect_valid;
    logic [11:0] i_redirect_pc;
    logic        o_if_valid;
    logic [11:0] o_if_pc;
    logic [31:0] o_if_instr;
    logic        o_pc_wrap;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 0;

    if_fetch_unit dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ack       (i_imem_ack),
        .i_imem_rdata     (i_imem_rdata),
        .i_stall          (i_stall),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_if_valid       (o_if_valid),
        .o_if_pc          (o_if_pc),
        .o_if_instr       (o_if_instr),
        .o_pc_wrap        (o_pc_wrap)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {20'hA5C30, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Memory responder: acks a request after ack_delay waiting cycles.
    initial begin
        int  wait_cnt;
        logic fired;
        wait_cnt     = 0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge i_clk or posedge i_reset);
            if (i_reset) begin
                i_imem_ack = 1'b0;
                wait_cnt   = 0;
            end else begin
                fired = i_imem_ack;
                #2;
                if (i_reset || !o_imem_req) begin
                    i_imem_ack   = 1'b0;
                    i_imem_rdata = 32'hDEAD_BEEF;
                    wait_cnt     = 0;
                end else begin
                    if (fired) wait_cnt = 0;
                    i_imem_ack   = (wait_cnt >= ack_delay);
                    i_imem_rdata = mem_word(o_imem_addr);
                    wait_cnt++;
                end
            end
        end
    end

    // Program-order model: every newly issued address and every instruction
    // shown to decode must follow the sequential stream, restarted at each
    // redirect target.
    initial begin
        logic [11:0] exp_pc, exp_issue, p_addr, p_pc;
        logic [31:0] p_instr;
        logic        p_req, p_fire, p_valid, p_stall, p_redir, new_issue;
        exp_pc = 12'h000; exp_issue = 12'h000;
        p_req = 1'b0; p_fire = 1'b0; p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
        p_addr = '0; p_pc = '0; p_instr = NOP;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                check("rst_req",   32'(o_imem_req),  32'(0));
                check("rst_addr",  32'(o_imem_addr), 32'(0));
                check("rst_valid", 32'(o_if_valid),  32'(0));
                check("rst_pc",    32'(o_if_pc),     32'(0));
                check("rst_instr", o_if_instr,       NOP);
                check("rst_wrap",  32'(o_pc_wrap),   32'(0));
                exp_pc = 12'h000; exp_issue = 12'h000;
                p_req = 1'b0; p_fire = 1'b0; p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
            end else begin
                new_issue = o_imem_req && (!p_req || p_fire);
                if (new_issue) begin
                    check("issue_addr", 32'(o_imem_addr), 32'(exp_issue));
                    check("issue_wrap", 32'(o_pc_wrap), 32'(exp_issue == 12'hFFC));
                    exp_issue = exp_issue + 12'd4;
                end else begin
                    check("idle_wrap", 32'(o_pc_wrap), 32'(0));
                end
                check("addr_align", 32'(o_imem_addr[1:0]), 32'(0));
                if (p_req && !p_fire) begin
                    check("req_hold",  32'(o_imem_req),  32'(1));
                    check("addr_hold", 32'(o_imem_addr), 32'(p_addr));
                end
                if (p_redir) begin
                    check("flush_valid", 32'(o_if_valid), 32'(0));
                end else if (p_valid && p_stall) begin
                    check("stall_valid", 32'(o_if_valid), 32'(1));
                    check("stall_pc",    32'(o_if_pc),    32'(p_pc));
                    check("stall_instr", o_if_instr,      p_instr);
                end
                if (o_if_valid) begin
                    check("if_pc",    32'(o_if_pc), 32'(exp_pc));
                    check("if_instr", o_if_instr,   mem_word(o_if_pc));
                end else begin
                    check("nop_instr", o_if_instr, NOP);
                end
                if (i_redirect_valid) begin
                    exp_pc    = i_redirect_pc & 12'hFFC;
                    exp_issue = i_redirect_pc & 12'hFFC;
                end else if (o_if_valid && !i_stall) begin
                    exp_pc = exp_pc + 12'd4;
                end
                p_req   = o_imem_req;
                p_fire  = o_imem_req && i_imem_ack;
                p_addr  = o_imem_addr;
                p_valid = o_if_valid;
                p_pc    = o_if_pc;
                p_instr = o_if_instr;
                p_stall = i_stall;
                p_redir = i_redirect_valid;
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        i_stall = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
        #1 i_reset = 1'b1;
        cyc(2);
        i_reset = 1'b0;

        // Streaming fetch, ack every cycle.
        cyc(1);
        check("e1_req",   32'(o_imem_req),  32'(1));
        check("e1_addr",  32'(o_imem_addr), 32'h000);
        check("e1_valid", 32'(o_if_valid),  32'(0));
        cyc(1);
        check("e2_valid", 32'(o_if_valid),  32'(1));
        check("e2_pc",    32'(o_if_pc),     32'h000);
        check("e2_instr", o_if_instr,       32'hA5C3_0000);
        check("e2_addr",  32'(o_imem_addr), 32'h004);
        cyc(8);
        check("e10_pc",   32'(o_if_pc),     32'h020);
        check("e10_addr", 32'(o_imem_addr), 32'h024);

        // Four-cycle stall: skid captures 024 and the request drops.
        i_stall = 1'b1;
        cyc(2);
        check("stall_req_drop", 32'(o_imem_req), 32'(0));
        check("stall_pc_020",   32'(o_if_pc),    32'h020);
        cyc(2);
        i_stall = 1'b0;
        cyc(1);
        check("skid_out_pc", 32'(o_if_pc),     32'h024);
        check("reissue",     32'(o_imem_addr), 32'h028);
        cyc(1);
        check("after_skid_pc", 32'(o_if_pc), 32'h028);

        // Slow memory: three waiting cycles per request.
        ack_delay = 3;
        cyc(3);
        check("slow_addr",  32'(o_imem_addr), 32'h02C);
        check("slow_wait",  32'(o_if_valid),  32'(0));
        cyc(1);
        check("slow_valid", 32'(o_if_valid),  32'(1));
        check("slow_pc",    32'(o_if_pc),     32'h02C);
        cyc(1);
        check("slow_pulse", 32'(o_if_valid),  32'(0));
        cyc(3);
        check("slow_pc2",   32'(o_if_pc),     32'h030);

        // Redirect while 034 is pending, then redirect (unaligned 123) while 010 is pending.
        i_redirect_valid = 1'b1; i_redirect_pc = 12'h010;
        cyc(1);
        i_redirect_valid = 1'b0;
        check("drain1_valid", 32'(o_if_valid),  32'(0));
        check("drain1_addr",  32'(o_imem_addr), 32'h034);
        cyc(3);
        check("tgt010_addr",  32'(o_imem_addr), 32'h010);
        cyc(1);
        i_redirect_valid = 1'b1; i_redirect_pc = 12'h123;
        cyc(1);
        i_redirect_valid = 1'b0;
        check("drain2_addr",  32'(o_imem_addr), 32'h010);
        cyc(2);
        check("tgt120_addr",  32'(o_imem_addr), 32'h120);
        check("tgt120_inval", 32'(o_if_valid),  32'(0));
        ack_delay = 0;
        cyc(1);
        check("tgt120_pc",    32'(o_if_pc),     32'h120);
        check("tgt120_instr", o_if_instr,       32'hA5C3_0120);

        // Redirect coincident with ack and stall.
        i_stall = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 12'h200;
        cyc(1);
        i_stall = 1'b0; i_redirect_valid = 1'b0;
        check("coin_valid", 32'(o_if_valid),  32'(0));
        check("coin_instr", o_if_instr,       NOP);
        check("coin_addr",  32'(o_imem_addr), 32'h200);
        cyc(1);
        check("coin_pc",    32'(o_if_pc),     32'h200);

        // PC wrap from FFC to 000.
        i_redirect_valid = 1'b1; i_redirect_pc = 12'hFF4;
        cyc(1);
        i_redirect_valid = 1'b0;
        check("wrap_ff4", 32'(o_imem_addr), 32'hFF4);
        cyc(2);
        check("wrap_ffc_addr", 32'(o_imem_addr), 32'hFFC);
        check("wrap_pulse",    32'(o_pc_wrap),   32'(1));
        cyc(1);
        check("wrap_000_addr", 32'(o_imem_addr), 32'h000);
        check("wrap_clear",    32'(o_pc_wrap),   32'(0));
        check("wrap_out_ffc",  32'(o_if_pc),     32'hFFC);
        cyc(1);
        check("wrap_out_000",  32'(o_if_pc),     32'h000);

        // Asynchronous reset in the middle of a stall.
        i_stall = 1'b1;
        cyc(2);
        #2 i_reset = 1'b1;
        #1;
        check("arst_req",   32'(o_imem_req),  32'(0));
        check("arst_addr",  32'(o_imem_addr), 32'(0));
        check("arst_valid", 32'(o_if_valid),  32'(0));
        check("arst_pc",    32'(o_if_pc),     32'(0));
        check("arst_instr", o_if_instr,       NOP);
        check("arst_wrap",  32'(o_pc_wrap),   32'(0));
        i_stall = 1'b0;
        cyc(2);
        i_reset = 1'b0;
        cyc(1);
        check("rerun_addr", 32'(o_imem_addr), 32'h000);
        cyc(3);
        check("rerun_pc",   32'(o_if_pc),     32'h008);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
